// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: table geometry, counter encodings,
// FSM states and the logical table entry layout.
package bp_pkg;

    localparam int XLEN  = 32;
    localparam int IDX_W = 6;
    localparam int TAG_W = 8;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic [1:0]       cnt;
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter, purely combinational next-value logic.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor plus tagged BTB, trained from the EX stage.
// Define BP_GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor
    import bp_pkg::*;
(
    input  logic            CLK,
    input  logic            rst,
    input  logic [XLEN-1:0] IF_PC,
    output logic            Pred_taken,
    output logic [XLEN-1:0] Pred_target,
    input  logic            EX_En,
    input  logic [XLEN-1:0] EX_PC,
    input  logic            EX_Branch_taken,
    input  logic [XLEN-1:0] EX_Target,
    input  logic            EX_Pred_taken,
    input  logic [XLEN-1:0] EX_Pred_target,
    output logic            Mispredict,
    output logic [XLEN-1:0] Redirect_PC,
    output logic            Busy
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;
    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;

    logic [1:0]       cnt_q    [DEPTH];
    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];

    logic [IDX_W-1:0] pred_bidx, pred_cidx, upd_bidx, upd_cidx;
    logic [1:0]       upd_cnt, upd_cnt_next;
    logic             upd_en;
    entry_t           rd_entry;

    assign pred_bidx = IF_PC[IDX_W+1:2];
    assign upd_bidx  = EX_PC[IDX_W+1:2];
    assign upd_en    = (state_q == RUN) && EX_En;

`ifdef BP_GSHARE_EN
    // History is architectural: it only advances on resolved branches.
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign pred_cidx = pred_bidx ^ ghr_q;
    assign upd_cidx  = upd_bidx ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (state_q == INIT) begin
            ghr_d = '0;
        end else if (EX_En) begin
            ghr_d = {ghr_q[IDX_W-2:0], EX_Branch_taken};
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    assign pred_cidx = pred_bidx;
    assign upd_cidx  = upd_bidx;
`endif

    assign upd_cnt = cnt_q[upd_cidx];

    bp_sat_counter u_sat_counter (
        .cnt_i   (upd_cnt),
        .taken_i (EX_Branch_taken),
        .cnt_o   (upd_cnt_next)
    );

    // Reads see the pre-write table contents; no write-to-read bypass.
    always_comb begin
        rd_entry.cnt    = cnt_q[pred_cidx];
        rd_entry.valid  = valid_q[pred_bidx];
        rd_entry.tag    = tag_q[pred_bidx];
        rd_entry.target = target_q[pred_bidx];
        Pred_taken  = (state_q == RUN) && rd_entry.cnt[1] && rd_entry.valid &&
                      (rd_entry.tag == IF_PC[IDX_W+2 +: TAG_W]);
        Pred_target = Pred_taken ? rd_entry.target : IF_PC + XLEN'(4);
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            if (state_q == INIT) begin
                cnt_q[walk_q]   <= WNT;
                valid_q[walk_q] <= 1'b0;
            end else if (upd_en) begin
                cnt_q[upd_cidx] <= upd_cnt_next;
                if (EX_Branch_taken) begin
                    valid_q[upd_bidx]  <= 1'b1;
                    tag_q[upd_bidx]    <= EX_PC[IDX_W+2 +: TAG_W];
                    target_q[upd_bidx] <= EX_Target;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        walk_d       = walk_q;
        mispredict_d = 1'b0;
        redirect_d   = redirect_q;
        if (state_q == INIT) begin
            walk_d = walk_q + IDX_W'(1);
            if (walk_q == '1) state_d = RUN;
        end else if (EX_En) begin
            mispredict_d = (EX_Pred_taken != EX_Branch_taken) ||
                           (EX_Pred_taken && EX_Branch_taken && (EX_Pred_target != EX_Target));
            redirect_d   = EX_Branch_taken ? EX_Target : EX_PC + XLEN'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= INIT;
            walk_q       <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            state_q      <= state_d;
            walk_q       <= walk_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    assign Mispredict  = mispredict_q;
    assign Redirect_PC = redirect_q;
    assign Busy        = (state_q == INIT);

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural model of the predictor tables.
module tb_branch_predictor;

    logic        CLK;
    logic        rst;
    logic [31:0] IF_PC;
    logic        Pred_taken;
    logic [31:0] Pred_target;
    logic        EX_En;
    logic [31:0] EX_PC;
    logic        EX_Branch_taken;
    logic [31:0] EX_Target;
    logic        EX_Pred_taken;
    logic [31:0] EX_Pred_target;
    logic        Mispredict;
    logic [31:0] Redirect_PC;
    logic        Busy;

    int tests_run;
    int tests_failed;

    // Behavioural model state
    int          m_cnt   [64];
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_init_left;
    int          m_ghr;
    bit          m_misp;
    logic [31:0] m_redir;

    branch_predictor dut (
        .CLK             (CLK),
        .rst             (rst),
        .IF_PC           (IF_PC),
        .Pred_taken      (Pred_taken),
        .Pred_target     (Pred_target),
        .EX_En           (EX_En),
        .EX_PC           (EX_PC),
        .EX_Branch_taken (EX_Branch_taken),
        .EX_Target       (EX_Target),
        .EX_Pred_taken   (EX_Pred_taken),
        .EX_Pred_target  (EX_Pred_target),
        .Mispredict      (Mispredict),
        .Redirect_PC     (Redirect_PC),
        .Busy            (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) & 32'hFF);
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int bi;
        int ci;
        bi = idx_of(pc);
        ci = bi ^ m_ghr;
        t  = (m_init_left == 0) && (m_cnt[ci] >= 2) && m_valid[bi] && (m_tag[bi] == tag_of(pc));
        tg = t ? m_tgt[bi] : pc + 32'd4;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int bi;
        int ci;
        if (rst) begin
            m_init_left = 64;
            m_misp      = 1'b0;
            m_redir     = 32'h0;
            m_ghr       = 0;
            for (int i = 0; i < 64; i++) begin
                m_cnt[i]   = 1;
                m_valid[i] = 1'b0;
            end
        end else if (m_init_left > 0) begin
            m_init_left = m_init_left - 1;
            m_misp      = 1'b0;
            m_ghr       = 0;
        end else begin
            m_misp = EX_En && ((EX_Pred_taken != EX_Branch_taken) ||
                     (EX_Pred_taken && EX_Branch_taken && (EX_Pred_target != EX_Target)));
            if (EX_En) begin
                m_redir = EX_Branch_taken ? EX_Target : EX_PC + 32'd4;
                bi = idx_of(EX_PC);
                ci = bi ^ m_ghr;
                if (EX_Branch_taken) begin
                    m_cnt[ci]  = (m_cnt[ci] == 3) ? 3 : m_cnt[ci] + 1;
                    m_valid[bi] = 1'b1;
                    m_tag[bi]   = tag_of(EX_PC);
                    m_tgt[bi]   = EX_Target;
                end else begin
                    m_cnt[ci] = (m_cnt[ci] == 0) ? 0 : m_cnt[ci] - 1;
                end
`ifdef BP_GSHARE_EN
                m_ghr = ((m_ghr << 1) | int'(EX_Branch_taken)) & 63;
`endif
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    // Drive an EX resolution whose carried prediction is the model's current prediction.
    task automatic drive_ex(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        bit          pt;
        logic [31:0] ptg;
        model_pred(pc, pt, ptg);
        EX_En           = 1'b1;
        EX_PC           = pc;
        EX_Branch_taken = taken;
        EX_Target       = tgt;
        EX_Pred_taken   = pt;
        EX_Pred_target  = ptg;
    endtask

    task automatic reset_wait();
        int n;
        rst   = 1'b1;
        EX_En = 1'b0;
        cycle();
        rst = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wait: got Busy=%0b expected 0 within 100 cycles", Busy);
        end
    endtask

    task automatic test_reset();
        int          busy_cycles;
        bit          et;
        logic [31:0] etg;
        rst   = 1'b1;
        EX_En = 1'b0;
        cycle();
        rst = 1'b0;
        tests_run++;
        if (Busy !== 1'b1 || Mispredict !== m_misp || Redirect_PC !== m_redir) begin
            tests_failed++;
            $display("FAIL reset_state: got Busy=%0b Misp=%0b Redir=%h expected Busy=1 Misp=%0b Redir=%h",
                     Busy, Mispredict, Redirect_PC, m_misp, m_redir);
        end
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 80) begin
            IF_PC           = $urandom;
            EX_En           = 1'($urandom_range(0, 1));
            EX_PC           = $urandom;
            EX_Branch_taken = 1'($urandom_range(0, 1));
            EX_Target       = $urandom;
            EX_Pred_taken   = 1'($urandom_range(0, 1));
            EX_Pred_target  = $urandom;
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL init_pred: pc=%h got t=%0b tgt=%h expected t=%0b tgt=%h",
                         IF_PC, Pred_taken, Pred_target, et, etg);
            end
            cycle();
            busy_cycles++;
            tests_run++;
            if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
                tests_failed++;
                $display("FAIL init_ex_ignored: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                         Mispredict, Redirect_PC, m_misp, m_redir);
            end
        end
        EX_En = 1'b0;
        tests_run++;
        if (busy_cycles != 64 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_length: got %0d cycles (Busy=%0b) expected 64 cycles", busy_cycles, Busy);
        end
        $display("[TB] reset: Busy held for %0d cycles", busy_cycles);
    endtask

    task automatic test_mispredict();
        bit          et;
        logic [31:0] etg;
        EX_En           = 1'b1;
        EX_PC           = 32'h100;
        EX_Branch_taken = 1'b1;
        EX_Target       = 32'h80;
        EX_Pred_taken   = 1'b0;
        EX_Pred_target  = 32'h104;
        cycle();
        EX_En = 1'b0;
        tests_run++;
        if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
            tests_failed++;
            $display("FAIL first_mispredict: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                     Mispredict, Redirect_PC, m_misp, m_redir);
        end
        $display("[TB] ex pc=00000100 taken=1 tgt=00000080 -> misp=%0b redir=%h", Mispredict, Redirect_PC);
        IF_PC = 32'h100;
        #1;
        model_pred(IF_PC, et, etg);
        tests_run++;
        if (Pred_taken !== et || Pred_target !== etg) begin
            tests_failed++;
            $display("FAIL trained_pred: got t=%0b tgt=%h expected t=%0b tgt=%h",
                     Pred_taken, Pred_target, et, etg);
        end
        cycle();
        tests_run++;
        if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
            tests_failed++;
            $display("FAIL idle_hold: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                     Mispredict, Redirect_PC, m_misp, m_redir);
        end
        // Direction right but target wrong must still mispredict.
        EX_En           = 1'b1;
        EX_PC           = 32'h100;
        EX_Branch_taken = 1'b1;
        EX_Target       = 32'h80;
        EX_Pred_taken   = 1'b1;
        EX_Pred_target  = 32'h84;
        cycle();
        EX_En = 1'b0;
        tests_run++;
        if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
            tests_failed++;
            $display("FAIL target_mismatch: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                     Mispredict, Redirect_PC, m_misp, m_redir);
        end
        $display("[TB] ex pc=00000100 wrong target -> misp=%0b redir=%h", Mispredict, Redirect_PC);
    endtask

    task automatic test_saturation();
        bit          et;
        logic [31:0] etg;
        bit          seq [7];
        seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        reset_wait();
        for (int i = 0; i < 7; i++) begin
            drive_ex(32'h100, seq[i], 32'h80);
            cycle();
            EX_En = 1'b0;
            tests_run++;
            if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
                tests_failed++;
                $display("FAIL sat_ex%0d: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                         i, Mispredict, Redirect_PC, m_misp, m_redir);
            end
            IF_PC = 32'h100;
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL sat_pred%0d: got t=%0b tgt=%h expected t=%0b tgt=%h",
                         i, Pred_taken, Pred_target, et, etg);
            end
            $display("[TB] sat step %0d taken=%0b -> pred=%0b misp=%0b", i, seq[i], Pred_taken, Mispredict);
        end
    endtask

    task automatic test_tag_miss();
        bit          et;
        logic [31:0] etg;
        logic [31:0] pcs [3];
        pcs = '{32'h4100, 32'h100, 32'h4100};
        drive_ex(32'h100, 1'b1, 32'h80);
        cycle();
        drive_ex(32'h100, 1'b1, 32'h80);
        cycle();
        // Not-taken at an aliasing PC trains the shared counter despite the tag miss.
        drive_ex(32'h4100, 1'b0, 32'h0);
        IF_PC = 32'h4100;
        #1;
        model_pred(IF_PC, et, etg);
        tests_run++;
        if (Pred_taken !== et || Pred_target !== etg) begin
            tests_failed++;
            $display("FAIL tag_miss_pred: got t=%0b tgt=%h expected t=%0b tgt=%h",
                     Pred_taken, Pred_target, et, etg);
        end
        cycle();
        EX_En = 1'b0;
        for (int i = 1; i < 3; i++) begin
            IF_PC = pcs[i];
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL tag_miss_train%0d: pc=%h got t=%0b tgt=%h expected t=%0b tgt=%h",
                         i, IF_PC, Pred_taken, Pred_target, et, etg);
            end
        end
        $display("[TB] tag miss: pc=00004100 pred=%0b", Pred_taken);
    endtask

    task automatic test_same_cycle();
        bit          et;
        logic [31:0] etg;
        drive_ex(32'h38, 1'b1, 32'h400);
        IF_PC = 32'h38;
        #1;
        model_pred(IF_PC, et, etg);
        tests_run++;
        if (Pred_taken !== et || Pred_target !== etg) begin
            tests_failed++;
            $display("FAIL same_cycle_old: got t=%0b tgt=%h expected t=%0b tgt=%h",
                     Pred_taken, Pred_target, et, etg);
        end
        cycle();
        EX_En = 1'b0;
        model_pred(IF_PC, et, etg);
        tests_run++;
        if (Pred_taken !== et || Pred_target !== etg) begin
            tests_failed++;
            $display("FAIL same_cycle_new: got t=%0b tgt=%h expected t=%0b tgt=%h",
                     Pred_taken, Pred_target, et, etg);
        end
        $display("[TB] same-cycle rw pc=00000038 -> pred after write=%0b", Pred_taken);
    endtask

    task automatic test_back_to_back();
        bit          et;
        logic [31:0] etg;
        bit          seq [5];
        seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive_ex(32'h2C, seq[i], 32'h600);
            cycle();
            tests_run++;
            if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
                tests_failed++;
                $display("FAIL b2b_ex%0d: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                         i, Mispredict, Redirect_PC, m_misp, m_redir);
            end
            IF_PC = 32'h2C;
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL b2b_pred%0d: got t=%0b tgt=%h expected t=%0b tgt=%h",
                         i, Pred_taken, Pred_target, et, etg);
            end
            $display("[TB] b2b step %0d taken=%0b -> misp=%0b pred=%0b", i, seq[i], Mispredict, Pred_taken);
        end
        EX_En = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        int          busy_cycles;
        bit          et;
        logic [31:0] etg;
        rst   = 1'b1;
        EX_En = 1'b0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        tests_run++;
        if (Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_init_busy: got Busy=%0b expected 1", Busy);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 100) begin
            cycle();
            busy_cycles++;
        end
        tests_run++;
        if (busy_cycles != 64) begin
            tests_failed++;
            $display("FAIL mid_init_restart: got %0d busy cycles expected 64", busy_cycles);
        end
        IF_PC = 32'h100;
        #1;
        model_pred(IF_PC, et, etg);
        tests_run++;
        if (Pred_taken !== et || Pred_target !== etg) begin
            tests_failed++;
            $display("FAIL mid_init_cleared: got t=%0b tgt=%h expected t=%0b tgt=%h",
                     Pred_taken, Pred_target, et, etg);
        end
        $display("[TB] reset mid-init: Busy held for %0d cycles", busy_cycles);
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        bit          et;
        logic [31:0] etg;
        bit          seq [3];
        logic [31:0] pcs [3];
        seq = '{1'b1, 1'b1, 1'b0};
        pcs = '{32'h100, 32'h118, 32'h104};
        reset_wait();
        for (int i = 0; i < 3; i++) begin
            drive_ex(32'h100, seq[i], 32'h80);
            cycle();
        end
        drive_ex(32'h100, 1'b1, 32'h80);
        cycle();
        EX_En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IF_PC = pcs[i];
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL gshare_pred%0d: pc=%h got t=%0b tgt=%h expected t=%0b tgt=%h",
                         i, IF_PC, Pred_taken, Pred_target, et, etg);
            end
            $display("[TB] gshare pc=%h -> pred=%0b", IF_PC, Pred_taken);
        end
    endtask
`endif

    function automatic logic [31:0] rand_pc();
        logic [7:0] t;
        case ($urandom_range(0, 2))
            0:       t = 8'h01;
            1:       t = 8'h41;
            default: t = 8'h00;
        endcase
        return {16'h0, t, 6'($urandom_range(0, 3)), 2'b00};
    endfunction

    task automatic test_random();
        bit          et;
        logic [31:0] etg;
        bit          pt;
        logic [31:0] ptg;
        logic [31:0] tgts [3];
        tgts = '{32'h80, 32'h200, 32'h1000};
        for (int n = 0; n < 300; n++) begin
            IF_PC           = rand_pc();
            EX_En           = ($urandom_range(0, 2) != 0);
            EX_PC           = rand_pc();
            EX_Branch_taken = 1'($urandom_range(0, 1));
            EX_Target       = tgts[$urandom_range(0, 2)];
            model_pred(EX_PC, pt, ptg);
            case ($urandom_range(0, 3))
                0:       pt = ~pt;
                1:       ptg = ptg ^ 32'h10;
                default: ;
            endcase
            EX_Pred_taken  = pt;
            EX_Pred_target = ptg;
            #1;
            model_pred(IF_PC, et, etg);
            tests_run++;
            if (Pred_taken !== et || Pred_target !== etg) begin
                tests_failed++;
                $display("FAIL rand_pred%0d: pc=%h got t=%0b tgt=%h expected t=%0b tgt=%h",
                         n, IF_PC, Pred_taken, Pred_target, et, etg);
            end
            cycle();
            tests_run++;
            if (Mispredict !== m_misp || Redirect_PC !== m_redir) begin
                tests_failed++;
                $display("FAIL rand_ex%0d: got Misp=%0b Redir=%h expected Misp=%0b Redir=%h",
                         n, Mispredict, Redirect_PC, m_misp, m_redir);
            end
            if (EX_En)
                $display("[TB] rand %0d ex pc=%h taken=%0b tgt=%h -> misp=%0b redir=%h",
                         n, EX_PC, EX_Branch_taken, EX_Target, Mispredict, Redirect_PC);
        end
        EX_En = 1'b0;
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        m_init_left     = 64;
        m_ghr           = 0;
        m_misp          = 1'b0;
        m_redir         = 32'h0;
        rst             = 1'b0;
        IF_PC           = 32'h0;
        EX_En           = 1'b0;
        EX_PC           = 32'h0;
        EX_Branch_taken = 1'b0;
        EX_Target       = 32'h0;
        EX_Pred_taken   = 1'b0;
        EX_Pred_target  = 32'h0;

        test_reset();
        test_mispredict();
        test_saturation();
        test_tag_miss();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_init();
`ifdef BP_GSHARE_EN
        test_gshare();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
